// File: rtl/data_memory_ws_if.sv
// Request/response bundle for data_memory_ws.
// master: drives the request fields (valid, write, address, size, signed, write_data) and
//         observes req_ready and the response (resp_valid, resp_read_data, resp_error).
// slave:  the memory side, with the opposite directions.
interface data_memory_ws_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_address, req_size, req_signed, req_write_data,
    input  req_ready, resp_valid, resp_read_data, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_address, req_size, req_signed, req_write_data,
    output req_ready, resp_valid, resp_read_data, resp_error
  );
endinterface

// File: rtl/data_memory_ws.sv
// Word-organised data memory with valid/ready request port and configurable wait states.
// Supports byte/half/word stores with byte lanes and sign/zero-extended loads, and reports
// misaligned, illegal-size and out-of-range accesses through resp_error.
// Ports:
//   clock - single clock, rising edge
//   reset - synchronous, active-high; aborts any request in flight
//   bus   - slave side of data_memory_ws_if (request fields, req_ready, response)
module data_memory_ws #(
  parameter int unsigned MEM_DEPTH      = 2048,
  parameter int unsigned WAIT_STATES    = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic              clock,
  input logic              reset,
  data_memory_ws_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        write_q, signed_q;
  logic [31:0] address_q, write_data_q;
  logic [1:0]  size_q;
  logic [31:0] read_data_q;
  logic        error_q;

  logic [31:0] mem [MEM_DEPTH];

  logic        accept, enter_resp;
  logic        eff_write, eff_signed;
  logic [31:0] eff_address, eff_write_data;
  logic [1:0]  eff_size;
  logic        acc_error;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word, rd_shift, load_data;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;

  assign accept = bus.req_valid && (state_q == StIdle);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          wait_cnt_d = WaitLoad;
          state_d    = (WAIT_STATES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself, so the live
  // request fields are used; otherwise the captured copy is.
  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  always_comb begin
    if (state_q == StIdle) begin
      eff_write      = bus.req_write;
      eff_signed     = bus.req_signed;
      eff_address    = bus.req_address;
      eff_write_data = bus.req_write_data;
      eff_size       = bus.req_size;
    end else begin
      eff_write      = write_q;
      eff_signed     = signed_q;
      eff_address    = address_q;
      eff_write_data = write_data_q;
      eff_size       = size_q;
    end
  end

  assign acc_error = (eff_size == 2'd3) ||
                     (eff_size == 2'd1 && eff_address[0]) ||
                     (eff_size == 2'd2 && eff_address[1:0] != 2'd0) ||
                     ((eff_address >> (AW + 2)) != 32'd0);

  assign word_idx = eff_address[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {eff_address[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = eff_address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'd0;
    lane_en   = 4'b0000;
    lane_data = eff_write_data;
    case (eff_size)
      2'd0: begin
        load_data = {{24{eff_signed & rd_byte[7]}}, rd_byte};
        lane_en   = 4'b0001 << eff_address[1:0];
        lane_data = {4{eff_write_data[7:0]}};
      end
      2'd1: begin
        load_data = {{16{eff_signed & rd_half[15]}}, rd_half};
        lane_en   = eff_address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{eff_write_data[15:0]}};
      end
      2'd2: begin
        load_data = rd_word;
        lane_en   = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      size_q       <= 2'd0;
    end else if (accept) begin
      write_q      <= bus.req_write;
      signed_q     <= bus.req_signed;
      address_q    <= bus.req_address;
      write_data_q <= bus.req_write_data;
      size_q       <= bus.req_size;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data_q <= 32'd0;
      error_q     <= 1'b0;
    end else if (enter_resp) begin
      error_q     <= acc_error;
      read_data_q <= (acc_error || eff_write) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[AW'(i)] <= 32'd0;
      end
    end else if (enter_resp && eff_write && !acc_error) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  // Handshake outputs are forced low while reset is held so nothing is issued or reported.
  assign bus.req_ready      = (state_q == StIdle) && !reset;
  assign bus.resp_valid     = (state_q == StResp) && !reset;
  assign bus.resp_read_data = read_data_q;
  assign bus.resp_error     = error_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: three instances (W=1 clearing, W=0, W=3 non-clearing)
// share the request fields; sel picks the instance that sees req_valid and is observed.
module tb_data_memory_ws;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, rst2, rst_dut2;
  logic        req_valid, req_write, req_signed;
  logic [31:0] req_address, req_write_data;
  logic [1:0]  req_size;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  data_memory_ws_if if0 ();
  data_memory_ws_if if1 ();
  data_memory_ws_if if2 ();

  assign rst_dut2 = rst | rst2;

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_write = req_write;
  assign if1.req_write = req_write;
  assign if2.req_write = req_write;
  assign if0.req_address = req_address;
  assign if1.req_address = req_address;
  assign if2.req_address = req_address;
  assign if0.req_size = req_size;
  assign if1.req_size = req_size;
  assign if2.req_size = req_size;
  assign if0.req_signed = req_signed;
  assign if1.req_signed = req_signed;
  assign if2.req_signed = req_signed;
  assign if0.req_write_data = req_write_data;
  assign if1.req_write_data = req_write_data;
  assign if2.req_write_data = req_write_data;

  data_memory_ws #(.MEM_DEPTH(2048), .WAIT_STATES(1), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clock(clock), .reset(rst), .bus(if0)
  );
  data_memory_ws #(.MEM_DEPTH(256), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clock(clock), .reset(rst), .bus(if1)
  );
  data_memory_ws #(.MEM_DEPTH(256), .WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clock(clock), .reset(rst_dut2), .bus(if2)
  );

  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  always_comb begin
    cur_ready = if0.req_ready;
    cur_valid = if0.resp_valid;
    cur_err   = if0.resp_error;
    cur_rdata = if0.resp_read_data;
    if (sel == 1) begin
      cur_ready = if1.req_ready;
      cur_valid = if1.resp_valid;
      cur_err   = if1.resp_error;
      cur_rdata = if1.resp_read_data;
    end else if (sel == 2) begin
      cur_ready = if2.req_ready;
      cur_valid = if2.resp_valid;
      cur_err   = if2.resp_error;
      cur_rdata = if2.resp_read_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance; called and returns at a falling edge.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic sg, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    int   lat;
    bit   got;
    logic [31:0] rd;
    logic er;
    int   exp_lat;
    exp_lat = (sel == 0) ? 2 : (sel == 1) ? 1 : 4;
    req_write = w; req_address = a; req_size = s; req_signed = sg; req_write_data = d;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !cur_ready; i++) @(negedge clock);
    chk({tag, " ready"}, 32'(cur_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; got = 0; rd = 32'd0; er = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (cur_valid) begin
        got = 1; rd = cur_rdata; er = cur_err;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " data"}, rd, exp_rd);
    chk({tag, " error"}, 32'(er), 32'(exp_err));
    @(negedge clock);
    chk({tag, " pulse"}, 32'(cur_valid), 32'd0);
  endtask

  // Hold req_valid high for 20 cycles and check the ready/valid cadence.
  task automatic sweep(input string tag, input int period, input int exp_pulses);
    int pulses, valids, overlap, badgap, last;
    pulses = 0; valids = 0; overlap = 0; badgap = 0; last = -1;
    req_write = 1'b0; req_address = 32'd0; req_size = 2'd2; req_signed = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (cur_ready) begin
        if (last >= 0 && c - last != period) badgap++;
        last = c;
        pulses++;
      end
      if (cur_valid) valids++;
      if (cur_ready && cur_valid) overlap++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clock);
    chk({tag, " ready pulses"}, 32'(pulses), 32'(exp_pulses));
    chk({tag, " valid pulses"}, 32'(valids), 32'(exp_pulses));
    chk({tag, " ready gaps"}, 32'(badgap), 32'd0);
    chk({tag, " overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    rst = 1'b1; rst2 = 1'b0; sel = 0;
    req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
    req_address = 32'd0; req_write_data = 32'd0; req_size = 2'd0;
    repeat (3) @(negedge clock);
    chk("reset ready", 32'(if0.req_ready), 32'd0);
    chk("reset valid", 32'(if0.resp_valid), 32'd0);
    chk("reset error", 32'(if0.resp_error), 32'd0);
    chk("reset data", if0.resp_read_data, 32'd0);
    rst = 1'b0;
    @(negedge clock);
    chk("ready after reset", 32'(if0.req_ready), 32'd1);

    // W=1, depth 2048
    xact("sw 10", 1, 32'h10, 2, 0, 32'hDEADBEEF, 32'h0, 0);
    xact("lw 10", 0, 32'h10, 2, 0, 32'h0, 32'hDEADBEEF, 0);
    xact("sb 11", 1, 32'h11, 0, 0, 32'h0000005A, 32'h0, 0);
    xact("lw 10 b", 0, 32'h10, 2, 0, 32'h0, 32'hDEAD5AEF, 0);
    xact("lb 13", 0, 32'h13, 0, 1, 32'h0, 32'hFFFFFFDE, 0);
    xact("lbu 13", 0, 32'h13, 0, 0, 32'h0, 32'h000000DE, 0);
    xact("lb 11", 0, 32'h11, 0, 1, 32'h0, 32'h0000005A, 0);
    xact("sh 22", 1, 32'h22, 1, 0, 32'h00008001, 32'h0, 0);
    xact("lw 20", 0, 32'h20, 2, 1, 32'h0, 32'h80010000, 0);
    xact("lh 22", 0, 32'h22, 1, 1, 32'h0, 32'hFFFF8001, 0);
    xact("lhu 22", 0, 32'h22, 1, 0, 32'h0, 32'h00008001, 0);
    xact("lhu 20", 0, 32'h20, 1, 0, 32'h0, 32'h00000000, 0);
    xact("sw 100", 1, 32'h100, 2, 0, 32'h11111111, 32'h0, 0);
    xact("lh 21 err", 0, 32'h21, 1, 1, 32'h0, 32'h0, 1);
    xact("sw 102 err", 1, 32'h102, 2, 0, 32'hFFFFFFFF, 32'h0, 1);
    xact("size3 err", 0, 32'h10, 3, 0, 32'h0, 32'h0, 1);
    xact("range err", 0, 32'h2000, 2, 0, 32'h0, 32'h0, 1);
    xact("lw 100", 0, 32'h100, 2, 0, 32'h0, 32'h11111111, 0);

    // W=0
    sel = 1;
    @(negedge clock);
    xact("w0 sw 8", 1, 32'h8, 2, 0, 32'h0BADF00D, 32'h0, 0);
    xact("w0 lw 8", 0, 32'h8, 2, 0, 32'h0, 32'h0BADF00D, 0);
    sweep("w0 sweep", 2, 10);

    // W=3, contents survive reset
    sel = 2;
    @(negedge clock);
    sweep("w3 sweep", 5, 4);
    xact("w3 sw 40", 1, 32'h40, 2, 0, 32'hCAFEF00D, 32'h0, 0);
    xact("w3 lw 40", 0, 32'h40, 2, 0, 32'h0, 32'hCAFEF00D, 0);
    req_write = 1'b1; req_address = 32'h40; req_size = 2'd2; req_write_data = 32'h00001234;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst2 = 1'b1;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (if2.resp_valid) vcount++;
      chk("mid reset ready", 32'(if2.req_ready), 32'd0);
      chk("mid reset data", if2.resp_read_data, 32'd0);
      chk("mid reset error", 32'(if2.resp_error), 32'd0);
    end
    rst2 = 1'b0;
    @(negedge clock);
    chk("ready after mid reset", 32'(if2.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (if2.resp_valid) vcount++;
      @(negedge clock);
    end
    chk("aborted store valid", 32'(vcount), 32'd0);
    xact("w3 lw 40 kept", 0, 32'h40, 2, 0, 32'h0, 32'hCAFEF00D, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
